// File: rtl/uart_pattern_ctrl_pkg.sv
// uart_ctrl_pkg: shared types, command constants and ASCII hex helpers for
// the UART pattern controller. Honours macro UART_PATTERN_CTRL_ECHO_EN (queue depth).
package uart_ctrl_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GET_ARG = 1'b1
    } parse_state_t;

    localparam logic [7:0] CMD_PATTERN = 8'h50;
    localparam logic [7:0] CMD_QUERY   = 8'h3F;
    localparam logic [7:0] RSP_ACK     = 8'h4B;

`ifdef UART_PATTERN_CTRL_ECHO_EN
    localparam int RESP_DEPTH = 4;
`else
    localparam int RESP_DEPTH = 2;
`endif

    // Push slots into the response queue, in queue order.
    localparam int PUSH_ECHO  = 0;
    localparam int PUSH_QUERY = 1;
    localparam int PUSH_ACK   = 2;
    localparam int NUM_PUSH   = 3;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) ||
               (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    function automatic logic [3:0] hex_to_nibble(input logic [7:0] b);
        logic [7:0] v;
        if (b <= 8'h39)
            v = b - 8'h30;
        else if (b <= 8'h46)
            v = b - 8'h37;
        else
            v = b - 8'h57;
        return v[3:0];
    endfunction

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_pattern_ctrl_if.sv
// uart_pattern_ctrl_if: UART rx/tx, frame sync and pattern-generator signals.
// master = environment side, slave = controller side.
interface uart_pattern_ctrl_if;

    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       i_TX_Active;
    logic       i_Frame_Start;
    logic       o_TX_DV;
    logic [7:0] o_TX_Byte;
    logic [3:0] o_Pattern;
    logic       o_Pending;
    logic [7:0] o_Display_Byte;
    logic       o_Cmd_Error;

    modport master (
        output i_RX_DV, i_RX_Byte, i_TX_Active, i_Frame_Start,
        input  o_TX_DV, o_TX_Byte, o_Pattern, o_Pending,
               o_Display_Byte, o_Cmd_Error
    );

    modport slave (
        input  i_RX_DV, i_RX_Byte, i_TX_Active, i_Frame_Start,
        output o_TX_DV, o_TX_Byte, o_Pattern, o_Pending,
               o_Display_Byte, o_Cmd_Error
    );

endinterface

// File: rtl/uart_pattern_ctrl_resp_fifo.sv
// resp_fifo: byte FIFO with several ordered push slots per cycle and one pop.
// Ports: i_Clk, i_Rst, push/push_data in, pop in, head/empty/full/drop out.
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int NPUSH = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [NPUSH-1:0]      push,
    input  logic [NPUSH-1:0][7:0] push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  empty,
    output logic                  full,
    output logic                  drop
);

    // DEPTH must be a power of two: pointers wrap by truncation.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    mem   [DEPTH];
    logic [7:0]    mem_n [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] space;
    logic [CW-1:0] acc;

    // A pop in the same cycle frees its slot for this cycle's pushes.
    always_comb begin
        mem_n = mem;
        acc   = '0;
        drop  = 1'b0;
        space = CW'(DEPTH) - count + CW'(pop);
        for (int k = 0; k < NPUSH; k++) begin
            if (push[k]) begin
                if (acc < space) begin
                    mem_n[wr_ptr + acc[AW-1:0]] = push_data[k];
                    acc = acc + CW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            mem    <= mem_n;
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + acc[AW-1:0];
            count  <= count + acc - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/uart_pattern_ctrl.sv
// uart_pattern_ctrl: ASCII command parser, frame-aligned pattern apply and
// shared UART TX response queue. Ports: i_Clk, i_Rst, bus (slave modport).
// Macro UART_PATTERN_CTRL_ECHO_EN: echo every rx byte, queue depth 4.
module uart_pattern_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int         TIMEOUT_CLKS  = 250000,
    parameter logic [3:0] RESET_PATTERN = 4'h0
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    uart_pattern_ctrl_if.slave  bus
);

    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    parse_state_t state, state_n;

    logic [TW-1:0] tmo_cnt;
    logic          timeout;

    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          rx_hex;
    logic          is_p;
    logic          is_q;

    logic          arg_done;
    logic          parse_err;
    logic          accepted;
    logic          apply;

    logic [3:0]    pattern_q;
    logic [3:0]    pend_val;
    logic          pending_q;
    logic [7:0]    disp_q;
    logic          err_q;
    logic          tx_dv_q;
    logic [7:0]    tx_byte_q;

    logic [NUM_PUSH-1:0]      push;
    logic [NUM_PUSH-1:0][7:0] push_data;
    logic [7:0]               head;
    logic                     empty;
    logic                     full;
    logic                     drop;
    logic                     launch;

    assign rx_dv   = bus.i_RX_DV;
    assign rx_byte = bus.i_RX_Byte;
    assign rx_hex  = is_hex(rx_byte);
    assign is_p    = (rx_byte == CMD_PATTERN);
    assign is_q    = (rx_byte == CMD_QUERY);

    // A byte arriving in the timeout cycle wins over the timeout.
    assign timeout = (state == GET_ARG) && !rx_dv &&
                     (tmo_cnt == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (rx_dv && is_p)
                    state_n = GET_ARG;
            end
            GET_ARG: begin
                if (rx_dv || timeout)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        arg_done  = 1'b0;
        parse_err = 1'b0;
        accepted  = 1'b0;
        push      = '0;
        push_data = '0;
`ifdef UART_PATTERN_CTRL_ECHO_EN
        push[PUSH_ECHO]      = rx_dv;
        push_data[PUSH_ECHO] = rx_byte;
`endif
        push_data[PUSH_QUERY] = nibble_to_hex(pattern_q);
        push_data[PUSH_ACK]   = RSP_ACK;
        push[PUSH_ACK]        = apply;
        unique case (state)
            IDLE: begin
                if (rx_dv) begin
                    if (is_p) begin
                        accepted = 1'b1;
                    end else if (is_q) begin
                        accepted         = 1'b1;
                        push[PUSH_QUERY] = 1'b1;
                    end else begin
`ifdef UART_PATTERN_CTRL_ECHO_EN
                        accepted = 1'b1;
`else
                        parse_err = 1'b1;
`endif
                    end
                end
            end
            GET_ARG: begin
                if (rx_dv) begin
                    if (rx_hex) begin
                        accepted = 1'b1;
                        arg_done = 1'b1;
                    end else begin
                        parse_err = 1'b1;
                    end
                end else if (timeout) begin
                    parse_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= '0;
        else if (!timeout)
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign apply = bus.i_Frame_Start && pending_q;

    // On apply, the register still holds the old pending value, so a
    // same-cycle argument becomes the next pending value.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            pattern_q <= RESET_PATTERN;
            pend_val  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (apply)
                pattern_q <= pend_val;
            if (arg_done) begin
                pend_val  <= hex_to_nibble(rx_byte);
                pending_q <= 1'b1;
            end else if (apply) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            disp_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accepted)
                disp_q <= rx_byte;
            err_q <= parse_err || drop;
        end
    end

    resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .NPUSH (NUM_PUSH)
    ) u_resp_fifo (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .push      (push),
        .push_data (push_data),
        .pop       (launch),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .drop      (drop)
    );

    // tx_dv_q high means the transmitter has not yet raised its busy flag.
    assign launch = !empty && !bus.i_TX_Active && !tx_dv_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            tx_dv_q <= launch;
            if (launch)
                tx_byte_q <= head;
        end
    end

    assign bus.o_TX_DV        = tx_dv_q;
    assign bus.o_TX_Byte      = tx_byte_q;
    assign bus.o_Pattern      = pattern_q;
    assign bus.o_Pending      = pending_q;
    assign bus.o_Display_Byte = disp_q;
    assign bus.o_Cmd_Error    = err_q;

    logic unused;
    assign unused = full;

endmodule

// File: tb/tb_uart_pattern_ctrl.sv
// tb_uart_pattern_ctrl: directed vectors for uart_pattern_ctrl (default build).
// TX launches and error pulses are logged on the falling edge.
module tb_uart_pattern_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_pattern_ctrl_if bus ();

    uart_pattern_ctrl #(
        .TIMEOUT_CLKS  (100),
        .RESET_PATTERN (4'h0)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] tx_log[$];
    int         err_cnt = 0;
    int         b2b_cnt = 0;
    logic       prev_dv = 1'b0;

    always @(negedge clk) begin
        if (bus.o_TX_DV === 1'b1) begin
            tx_log.push_back(bus.o_TX_Byte);
            if (prev_dv)
                b2b_cnt++;
        end
        prev_dv = (bus.o_TX_DV === 1'b1);
        if (bus.o_Cmd_Error === 1'b1)
            err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_RX_DV   = 1'b1;
        bus.i_RX_Byte = b;
        tick();
        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
    endtask

    task automatic frame();
        bus.i_Frame_Start = 1'b1;
        tick();
        bus.i_Frame_Start = 1'b0;
    endtask

    task automatic chk_tx1(input string tag, input logic [7:0] exp);
        chk({tag, "_cnt"}, 32'(tx_log.size()), 32'd1);
        if (tx_log.size() > 0)
            chk({tag, "_byte"}, 32'(tx_log[0]), 32'(exp));
        tx_log.delete();
    endtask

    int e0;

    initial begin
        bus.i_RX_DV       = 1'b0;
        bus.i_RX_Byte     = 8'h00;
        bus.i_TX_Active   = 1'b0;
        bus.i_Frame_Start = 1'b0;
        ticks(3);

        chk("rst_pattern", 32'(bus.o_Pattern), 32'h0);
        chk("rst_pending", 32'(bus.o_Pending), 32'h0);
        chk("rst_tx_dv", 32'(bus.o_TX_DV), 32'h0);
        chk("rst_tx_byte", 32'(bus.o_TX_Byte), 32'h0);
        chk("rst_disp", 32'(bus.o_Display_Byte), 32'h0);
        chk("rst_err", 32'(bus.o_Cmd_Error), 32'h0);
        rst = 1'b0;
        ticks(2);

        send(8'h3F);
        ticks(10);
        chk_tx1("query0", 8'h30);
        chk("query0_pat", 32'(bus.o_Pattern), 32'h0);
        chk("query0_disp", 32'(bus.o_Display_Byte), 32'h3F);

        send(8'h50);
        send(8'h37);
        ticks(5);
        chk("p7_pending", 32'(bus.o_Pending), 32'h1);
        chk("p7_pat_hold", 32'(bus.o_Pattern), 32'h0);
        chk("p7_disp", 32'(bus.o_Display_Byte), 32'h37);
        chk("p7_no_tx", 32'(tx_log.size()), 32'd0);
        frame();
        chk("p7_pat", 32'(bus.o_Pattern), 32'h7);
        chk("p7_pend_clr", 32'(bus.o_Pending), 32'h0);
        ticks(10);
        chk_tx1("p7_ack", 8'h4B);

        send(8'h50);
        send(8'h33);
        send(8'h50);
        send(8'h61);
        ticks(3);
        chk("pa_pending", 32'(bus.o_Pending), 32'h1);
        chk("pa_pat_hold", 32'(bus.o_Pattern), 32'h7);
        frame();
        chk("pa_pat", 32'(bus.o_Pattern), 32'hA);
        ticks(10);
        chk_tx1("pa_ack", 8'h4B);
        frame();
        ticks(10);
        chk("pa_no_2nd_ack", 32'(tx_log.size()), 32'd0);

        e0 = err_cnt;
        send(8'h50);
        ticks(90);
        chk("tmo_early", 32'(err_cnt - e0), 32'd0);
        ticks(30);
        chk("tmo_err", 32'(err_cnt - e0), 32'd1);
        chk("tmo_pending", 32'(bus.o_Pending), 32'h0);
        send(8'h3F);
        ticks(10);
        chk_tx1("tmo_query", 8'h41);

        e0 = err_cnt;
        send(8'h50);
        send(8'h47);
        ticks(3);
        chk("pg_err", 32'(err_cnt - e0), 32'd1);
        chk("pg_pending", 32'(bus.o_Pending), 32'h0);
        send(8'h5A);
        ticks(3);
        chk("bad_err", 32'(err_cnt - e0), 32'd2);
        chk("bad_no_tx", 32'(tx_log.size()), 32'd0);

        bus.i_TX_Active = 1'b1;
        e0 = err_cnt;
        b2b_cnt = 0;
        send(8'h50);
        send(8'h35);
        ticks(2);
        frame();
        ticks(2);
        send(8'h3F);
        ticks(2);
        chk("full_no_err", 32'(err_cnt - e0), 32'd0);
        send(8'h3F);
        ticks(3);
        chk("full_err", 32'(err_cnt - e0), 32'd1);
        chk("held_no_tx", 32'(tx_log.size()), 32'd0);
        bus.i_TX_Active = 1'b0;
        ticks(20);
        chk("rel_cnt", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() == 2) begin
            chk("rel_first", 32'(tx_log[0]), 32'h4B);
            chk("rel_second", 32'(tx_log[1]), 32'h35);
        end
        chk("rel_b2b", 32'(b2b_cnt), 32'd0);
        tx_log.delete();

        send(8'h50);
        send(8'h39);
        ticks(2);
        rst = 1'b1;
        #1;
        chk("mid_rst_pat", 32'(bus.o_Pattern), 32'h0);
        chk("mid_rst_pend", 32'(bus.o_Pending), 32'h0);
        ticks(2);
        rst = 1'b0;
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
